// File: rtl/inventory_cmd_entry.sv
// Front-panel input stage: synchronizes switches, debounces the SAVE/SUBMIT keys and
// assembles a (mode, code, quant) command handed to the inventory core over valid/ready.
module inventory_cmd_entry #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_sw,
  input  logic              c_q_sw,
  input  logic [DATA_W-1:0] in_sw,
  input  logic              save_btn_n,
  input  logic              submit_btn_n,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_mode,
  output logic [DATA_W-1:0] cmd_code,
  output logic [DATA_W-1:0] cmd_quant,
  output logic              code_loaded,
  output logic              quant_loaded,
  output logic              err
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int KEY_SAVE   = 0;
  localparam int KEY_SUBMIT = 1;

  typedef enum logic {IDLE, PEND} state_t;

  logic [1:0]              key_s1_q, key_s2_q;
  logic                    mode_s1_q, mode_s2_q;
  logic                    cq_s1_q, cq_s2_q;
  logic [DATA_W-1:0]       in_s1_q, in_s2_q;

  logic [1:0]              db_q;
  logic [1:0]              press_q;
  logic [1:0][CNT_W-1:0]   cnt_q;

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [DATA_W-1:0]       code_q, code_d;
  logic [DATA_W-1:0]       quant_q, quant_d;
  logic                    cl_q, cl_d;
  logic                    ql_q, ql_d;
  logic                    err_q, err_d;

  // Two-flop synchronizers; keys idle high (released)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q  <= 2'b11;
      key_s2_q  <= 2'b11;
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
      cq_s1_q   <= 1'b0;
      cq_s2_q   <= 1'b0;
      in_s1_q   <= '0;
      in_s2_q   <= '0;
    end else begin
      key_s1_q  <= {submit_btn_n, save_btn_n};
      key_s2_q  <= key_s1_q;
      mode_s1_q <= mode_sw;
      mode_s2_q <= mode_s1_q;
      cq_s1_q   <= c_q_sw;
      cq_s2_q   <= cq_s1_q;
      in_s1_q   <= in_sw;
      in_s2_q   <= in_s1_q;
    end
  end

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q    <= 2'b11;
      press_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (key_s2_q[k] == db_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CNT_MAX) begin
          db_q[k]    <= key_s2_q[k];
          cnt_q[k]   <= '0;
          press_q[k] <= ~key_s2_q[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      code_q  <= '0;
      quant_q <= '0;
      cl_q    <= 1'b0;
      ql_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      code_q  <= code_d;
      quant_q <= quant_d;
      cl_q    <= cl_d;
      ql_q    <= ql_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    code_d  = code_q;
    quant_d = quant_q;
    cl_d    = cl_q;
    ql_d    = ql_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (press_q[KEY_SAVE]) begin
          if (cq_s2_q) begin
            code_d = in_s2_q;
            cl_d   = 1'b1;
          end else begin
            quant_d = in_s2_q;
            ql_d    = 1'b1;
          end
          err_d = 1'b0;
        end
        // Submit sees the post-save flags and fields, so a coincident save is included
        if (press_q[KEY_SUBMIT]) begin
          if (cl_d && ql_d) begin
            mode_d  = mode_s2_q;
            err_d   = 1'b0;
            state_d = PEND;
          end else begin
            err_d   = 1'b1;
            code_d  = code_q;
            quant_d = quant_q;
            cl_d    = cl_q;
            ql_d    = ql_q;
          end
        end
      end
      PEND: begin
        if (cmd_ready) begin
          state_d = IDLE;
          cl_d    = 1'b0;
          ql_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_valid    = (state_q == PEND);
  assign cmd_mode     = mode_q;
  assign cmd_code     = code_q;
  assign cmd_quant    = quant_q;
  assign code_loaded  = cl_q;
  assign quant_loaded = ql_q;
  assign err          = err_q;

endmodule

// File: tb/tb_inventory_cmd_entry.sv
// Directed bench for inventory_cmd_entry with DEBOUNCE_CYCLES=4; commands expected by the
// stimulus are queued and compared against each observed valid/ready transfer.
module tb_inventory_cmd_entry;

  localparam int DATA_W = 8;
  localparam int DC     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode_sw, c_q_sw;
  logic [DATA_W-1:0] in_sw;
  logic              save_btn_n, submit_btn_n;
  logic              cmd_valid, cmd_ready, cmd_mode;
  logic [DATA_W-1:0] cmd_code, cmd_quant;
  logic              code_loaded, quant_loaded, err;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_xfer = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  inventory_cmd_entry #(.DATA_W(DATA_W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .mode_sw(mode_sw), .c_q_sw(c_q_sw), .in_sw(in_sw),
    .save_btn_n(save_btn_n), .submit_btn_n(submit_btn_n), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_code(cmd_code),
    .cmd_quant(cmd_quant), .code_loaded(code_loaded), .quant_loaded(quant_loaded),
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit sv, input bit sm);
    if (sv) save_btn_n = 1'b0;
    if (sm) submit_btn_n = 1'b0;
    repeat (8) tick();
    save_btn_n   = 1'b1;
    submit_btn_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic save(input bit cq, input logic [DATA_W-1:0] v);
    c_q_sw = cq;
    in_sw  = v;
    press(1'b1, 1'b0);
  endtask

  // Transfer monitor: sampled on the falling edge, the transfer happens on the next rising edge
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      n_xfer++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL xfer_unexpected: observed %0h expected none", {cmd_mode, cmd_code, cmd_quant});
      end else begin
        chk("xfer_cmd", {15'd0, cmd_mode, cmd_code, cmd_quant}, {15'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mode_sw = 1'b0; c_q_sw = 1'b0; in_sw = '0;
    save_btn_n = 1'b1; submit_btn_n = 1'b1; cmd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_outs", {cmd_valid, cmd_mode, code_loaded, quant_loaded, err, cmd_code, cmd_quant},
        '0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 3-cycle glitch is rejected
    c_q_sw = 1'b1; in_sw = 8'h99;
    save_btn_n = 1'b0;
    repeat (3) tick();
    save_btn_n = 1'b1;
    repeat (12) tick();
    chk("glitch_code_loaded", code_loaded, 1'b0);
    chk("glitch_quant_loaded", quant_loaded, 1'b0);

    // Press latency: pulse in cycle 2+DC, flag visible one cycle later
    c_q_sw = 1'b1; in_sw = 8'h2A;
    save_btn_n = 1'b0;
    repeat (6) tick();
    chk("lat_before", code_loaded, 1'b0);
    tick();
    chk("lat_after", code_loaded, 1'b1);
    chk("lat_code", cmd_code, 8'h2A);
    save_btn_n = 1'b1;
    repeat (8) tick();

    save(1'b0, 8'h05);
    chk("main_quant_loaded", quant_loaded, 1'b1);
    mode_sw = 1'b1;
    sb.push_back({1'b1, 8'h2A, 8'h05});
    press(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("main_hold", {cmd_valid, cmd_mode, cmd_code, cmd_quant}, {1'b1, 1'b1, 8'h2A, 8'h05});
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("main_valid_drop", cmd_valid, 1'b0);
    chk("main_flags_clr", {code_loaded, quant_loaded}, 2'b00);
    cmd_ready = 1'b0;

    // Incomplete submit sets err; a save clears it
    save(1'b1, 8'h11);
    press(1'b0, 1'b1);
    chk("inc_err", err, 1'b1);
    chk("inc_valid", cmd_valid, 1'b0);
    save(1'b0, 8'h22);
    chk("inc_err_clr", err, 1'b0);
    mode_sw = 1'b0;
    sb.push_back({1'b0, 8'h11, 8'h22});
    press(1'b0, 1'b1);
    chk("inc_issue", {cmd_valid, cmd_mode, cmd_code, cmd_quant}, {1'b1, 1'b0, 8'h11, 8'h22});

    // Keys and switches are ignored while pending
    mode_sw = 1'b1; c_q_sw = 1'b1; in_sw = 8'hFF;
    press(1'b1, 1'b1);
    c_q_sw = 1'b0;
    press(1'b1, 1'b0);
    chk("pend_hold", {cmd_valid, cmd_mode, cmd_code, cmd_quant}, {1'b1, 1'b0, 8'h11, 8'h22});
    begin
      int x0;
      x0 = n_xfer;
      cmd_ready = 1'b1;
      repeat (6) tick();
      cmd_ready = 1'b0;
      chk("pend_one_xfer", n_xfer - x0, 1);
    end
    chk("pend_flags_clr", {code_loaded, quant_loaded}, 2'b00);

    // Coincident save and submit: save lands first and is part of the command
    save(1'b1, 8'h33);
    press(1'b0, 1'b1);
    chk("same_pre_err", err, 1'b1);
    c_q_sw = 1'b0; in_sw = 8'h07; mode_sw = 1'b1;
    sb.push_back({1'b1, 8'h33, 8'h07});
    press(1'b1, 1'b1);
    chk("same_issue", {cmd_valid, cmd_mode, cmd_code, cmd_quant}, {1'b1, 1'b1, 8'h33, 8'h07});
    chk("same_err", err, 1'b0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("same_done", cmd_valid, 1'b0);

    // Asynchronous reset while pending drops the command
    save(1'b1, 8'h44);
    save(1'b0, 8'h55);
    sb.push_back({1'b1, 8'h44, 8'h55});
    press(1'b0, 1'b1);
    chk("rst_pre_valid", cmd_valid, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", cmd_valid, 1'b0);
    chk("rst_async_outs", {cmd_mode, code_loaded, quant_loaded, err, cmd_code, cmd_quant}, '0);
    void'(sb.pop_back());
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    press(1'b0, 1'b1);
    chk("rst_after_err", err, 1'b1);
    chk("rst_after_valid", cmd_valid, 1'b0);

    chk("sb_empty", sb.size(), 0);
    chk("xfer_total", n_xfer, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
